// File: rtl/square_pkg.sv
// Shared types and helpers for the sequential squarer.
package square_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit counter width; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/square_nbit_seq_if.sv
// Valid/ready operand and result channels of the sequential squarer.
interface square_nbit_seq_if #(
  parameter int WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out;
  logic                 busy;

  modport master (
    output in_valid, in, out_ready,
    input  in_ready, out_valid, out, busy
  );

  modport slave (
    input  in_valid, in, out_ready,
    output in_ready, out_valid, out, busy
  );
endinterface

// File: rtl/square_abs.sv
// Operand conditioning: two's-complement magnitude when SIGNED, else pass-through.
module square_abs #(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] mag
);

  // The most negative value negates to itself, which read unsigned is 2^(WIDTH-1).
  always_comb begin
    mag = in;
    if (SIGNED && in[WIDTH-1]) begin
      mag = ~in + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/square_nbit_seq.sv
// Radix-2 shift-add squarer: one multiplier bit per cycle, valid/ready on both sides.
module square_nbit_seq
  import square_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  square_nbit_seq_if.slave    bus
);

  localparam int CW = cnt_width(WIDTH);
  localparam int PW = 2 * WIDTH;

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] mag;

  square_abs #(
    .WIDTH  (WIDTH),
    .SIGNED (SIGNED)
  ) u_abs (
    .in  (bus.in),
    .mag (mag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          mcand_d  = mag;
          mplier_d = mag;
          count_d  = '0;
          acc_d    = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        // Partial product for this bit is the multiplicand weighted by its position.
        if (mplier_q[0]) begin
          acc_d = acc_q + ({{WIDTH{1'b0}}, mcand_q} << count_q);
        end
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out       = acc_q;

endmodule
